// File: rtl/rvc_asap_5pl_dmem_arb.sv
// -----------------------------------------------------------------------------
// rvc_asap_5pl_dmem_arb
//
// Shares the single-ported, sync-read data memory between the core load/store
// port (port C, memory stage) and an external master port (port E, e.g. a debug
// loader or DMA). Port C has fixed priority. A starvation counter forces a
// port-E grant after STARVE_LIMIT consecutive denied port-E request cycles.
// Read data returns one cycle after the grant with a per-port valid strobe.
//
// Optional feature macro: RVC_DMEM_ARB_LOCK_EN
//   Adds input ExtLock. A port-E grant with ExtLock = 1 locks the memory to
//   port E (E_LOCK) until the first cycle ExtLock is low.
//
// Ports:
//   Clock, Rst        core clock, synchronous active-high reset
//   Core*             port C request fields in; CoreGnt (combinational),
//                     CoreRspValid / CoreRdData read response out
//   Ext*              port E request fields in; ExtGnt, ExtRspValid /
//                     ExtRdData out (ExtLock in, with the lock feature only)
//   Mem*              D_MEM side: muxed address/data/byte-enables and
//                     write/read enables out, MemRdData in (1-cycle latency)
// -----------------------------------------------------------------------------
module rvc_asap_5pl_dmem_arb #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4    // legal range 1..15 (4-bit counter)
) (
  input  logic                Clock,
  input  logic                Rst,
  input  logic                CoreReq,
  input  logic                CoreWrEn,
  input  logic [ADDR_W-1:0]   CoreAddr,
  input  logic [DATA_W-1:0]   CoreWrData,
  input  logic [DATA_W/8-1:0] CoreByteEn,
  output logic                CoreGnt,
  output logic                CoreRspValid,
  output logic [DATA_W-1:0]   CoreRdData,
  input  logic                ExtReq,
  input  logic                ExtWrEn,
  input  logic [ADDR_W-1:0]   ExtAddr,
  input  logic [DATA_W-1:0]   ExtWrData,
  input  logic [DATA_W/8-1:0] ExtByteEn,
`ifdef RVC_DMEM_ARB_LOCK_EN
  input  logic                ExtLock,
`endif
  output logic                ExtGnt,
  output logic                ExtRspValid,
  output logic [DATA_W-1:0]   ExtRdData,
  output logic [ADDR_W-1:0]   MemAddr,
  output logic [DATA_W-1:0]   MemWrData,
  output logic [DATA_W/8-1:0] MemByteEn,
  output logic                MemWrEn,
  output logic                MemRdEn,
  input  logic [DATA_W-1:0]   MemRdData
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

`ifdef RVC_DMEM_ARB_LOCK_EN
  typedef enum logic [1:0] {C_PRI = 2'd0, E_FORCE = 2'd1, E_LOCK = 2'd2} arb_state_e;
`else
  typedef enum logic [1:0] {C_PRI = 2'd0, E_FORCE = 2'd1} arb_state_e;
`endif

  arb_state_e state_q, state_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic       core_rsp_q, ext_rsp_q;
  logic       core_gnt, ext_gnt;

  // Arbitration. Grants are combinational so the memory sees the request in
  // the same cycle the master presents it.
  // NOTE: every signal assigned in an always_comb gets a default at the top,
  // otherwise an uncovered path infers a latch.
  always_comb begin
    core_gnt = 1'b0;
    ext_gnt  = 1'b0;
    if (!Rst) begin
      case (state_q)
        E_FORCE: begin
          ext_gnt  = ExtReq;
          core_gnt = CoreReq & ~ExtReq;
        end
`ifdef RVC_DMEM_ARB_LOCK_EN
        E_LOCK: begin
          ext_gnt  = ExtReq;     // core is shut out even when port E idles
        end
`endif
        default: begin
          core_gnt = CoreReq;
          ext_gnt  = ExtReq & ~CoreReq;
        end
      endcase
    end
  end

  // Starvation counter: counts consecutive denied port-E request cycles and
  // clears whenever port E is granted or stops requesting.
  always_comb begin
    starve_cnt_d = '0;
    if (ExtReq && !ext_gnt) begin
      starve_cnt_d = (starve_cnt_q == 4'hF) ? 4'hF : starve_cnt_q + 4'd1;
    end
`ifdef RVC_DMEM_ARB_LOCK_EN
    if (state_q == E_LOCK) begin
      starve_cnt_d = '0;
    end
`endif
  end

  // Next state. Reaching the limit this cycle gives port E priority for
  // exactly the following cycle; the core still wins the current one.
  always_comb begin
    state_d = C_PRI;
    case (state_q)
      C_PRI:   state_d = (starve_cnt_d >= LIMIT) ? E_FORCE : C_PRI;
      E_FORCE: state_d = C_PRI;
`ifdef RVC_DMEM_ARB_LOCK_EN
      E_LOCK:  state_d = ExtLock ? E_LOCK : C_PRI;
`endif
      default: state_d = C_PRI;
    endcase
`ifdef RVC_DMEM_ARB_LOCK_EN
    if (ext_gnt && ExtLock) begin
      state_d = E_LOCK;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge Clock) begin
    if (Rst) begin
      state_q      <= C_PRI;
      starve_cnt_q <= '0;
      core_rsp_q   <= 1'b0;
      ext_rsp_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      // Owner tags: a granted read owns the MemRdData of the next cycle.
      core_rsp_q   <= core_gnt & ~CoreWrEn;
      ext_rsp_q    <= ext_gnt & ~ExtWrEn;
    end
  end

  // Memory-side mux; all fields are zero when nobody is granted.
  always_comb begin
    MemAddr   = '0;
    MemWrData = '0;
    MemByteEn = '0;
    MemWrEn   = 1'b0;
    MemRdEn   = 1'b0;
    if (core_gnt) begin
      MemAddr   = CoreAddr;
      MemWrData = CoreWrData;
      MemByteEn = CoreByteEn;
      MemWrEn   = CoreWrEn;
      MemRdEn   = ~CoreWrEn;
    end else if (ext_gnt) begin
      MemAddr   = ExtAddr;
      MemWrData = ExtWrData;
      MemByteEn = ExtByteEn;
      MemWrEn   = ExtWrEn;
      MemRdEn   = ~ExtWrEn;
    end
  end

  assign CoreGnt = core_gnt;
  assign ExtGnt  = ext_gnt;

  // A response owed from the cycle before reset is suppressed while Rst is
  // high; the tags themselves clear on the reset edge.
  assign CoreRspValid = core_rsp_q & ~Rst;
  assign ExtRspValid  = ext_rsp_q & ~Rst;
  assign CoreRdData   = CoreRspValid ? MemRdData : '0;
  assign ExtRdData    = ExtRspValid ? MemRdData : '0;

endmodule
